// File: rtl/cheri_dmem_responder.sv
// cheri_dmem_responder: flop-array data memory with per-word capability tags,
// SECDED-checked writes and fixed-latency in-order responses.
// Ports:
//   clk_i, rst_i (async, active-high), stall_i (back-pressure)
//   data_req_i, data_is_cap_i, data_we_i, data_be_i, data_addr_i,
//   data_wdata_i (bit 32 = tag), data_wdata_intg_i
//   data_gnt_o, data_rvalid_o, data_rdata_o (bit 32 = tag),
//   data_rdata_intg_o, data_err_o
module cheri_dmem_responder #(
  parameter logic [31:0] AddrBase       = 32'h2000_0000,
  parameter int          DepthWords     = 256,
  parameter int          Latency        = 1,
  parameter int          MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        data_req_i,
  input  logic        data_is_cap_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [32:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [32:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o
);

  localparam int IW = $clog2(DepthWords);
  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam logic [31:0] AddrLimit = AddrBase + 32'(4 * DepthWords);

  // Inverted SECDED(39,32) check bits.
  function automatic logic [6:0] secded_enc(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606_BD25);
    c[1] = ^(d & 32'hDEBA_8050);
    c[2] = ^(d & 32'h413D_89AA);
    c[3] = ^(d & 32'h3123_4ED1);
    c[4] = ^(d & 32'hC2C1_323B);
    c[5] = ^(d & 32'h2DCC_624C);
    c[6] = ^(d & 32'h9850_5586);
    return c ^ 7'h2A;
  endfunction

  logic [32:0]   mem_q [DepthWords];
  logic [CW-1:0] outst_q, outst_d;
  logic          pv_q [Latency];
  logic [32:0]   pd_q [Latency];
  logic          pe_q [Latency];

  logic [31:0]   off;
  logic [IW-1:0] idx;
  logic          in_rng, mis, intg_bad, req_err, gnt, rvalid;
  logic [32:0]   word, wr_d, rsp_d;

  assign rvalid = pv_q[Latency-1];

  always_comb begin
    off      = data_addr_i - AddrBase;
    idx      = IW'(off >> 2);
    in_rng   = (data_addr_i >= AddrBase) && (data_addr_i < AddrLimit);
    mis      = |data_addr_i[1:0];
    intg_bad = data_we_i &&
               (secded_enc(data_wdata_i[31:0]) != data_wdata_intg_i);
    req_err  = !in_rng || mis || intg_bad;
    word     = mem_q[idx];
    gnt      = data_req_i && !stall_i && !rst_i &&
               (outst_q < CW'(MaxOutstanding));
    // Merge enabled bytes; only a full-word capability store keeps a tag.
    wr_d = word;
    for (int k = 0; k < 4; k++) begin
      if (data_be_i[k]) wr_d[8*k +: 8] = data_wdata_i[8*k +: 8];
    end
    wr_d[32] = data_is_cap_i && (data_be_i == 4'hF) && data_wdata_i[32];
    rsp_d = '0;
    if (!data_we_i && !req_err) begin
      rsp_d = {word[32] & data_is_cap_i, word[31:0]};
    end
    // Grant and retire together leave the count unchanged.
    outst_d = outst_q;
    if (gnt && !rvalid) outst_d = outst_q + CW'(1);
    else if (!gnt && rvalid) outst_d = outst_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DepthWords; i++) mem_q[i] <= '0;
    end else if (gnt && data_we_i && !req_err) begin
      mem_q[idx] <= wr_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q <= '0;
      for (int s = 0; s < Latency; s++) begin
        pv_q[s] <= 1'b0;
        pd_q[s] <= '0;
        pe_q[s] <= 1'b0;
      end
    end else begin
      outst_q <= outst_d;
      pv_q[0] <= gnt;
      pd_q[0] <= gnt ? rsp_d : '0;
      pe_q[0] <= gnt && req_err;
      for (int s = 1; s < Latency; s++) begin
        pv_q[s] <= pv_q[s-1];
        pd_q[s] <= pd_q[s-1];
        pe_q[s] <= pe_q[s-1];
      end
    end
  end

  assign data_gnt_o        = gnt;
  assign data_rvalid_o     = rvalid;
  assign data_rdata_o      = pd_q[Latency-1];
  assign data_err_o        = pe_q[Latency-1];
  assign data_rdata_intg_o = secded_enc(data_rdata_o[31:0]);

endmodule

// File: tb/tb_cheri_dmem_responder.sv
// tb_cheri_dmem_responder: directed self-checking bench for
// cheri_dmem_responder, instantiated with Latency=2, MaxOutstanding=2.
module tb_cheri_dmem_responder;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        req = 1'b0;
  logic        cap = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [32:0] wdata = '0;
  logic [6:0]  wintg = '0;
  logic        gnt, rvalid, err;
  logic [32:0] rdata;
  logic [6:0]  rintg;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cheri_dmem_responder #(
    .AddrBase(32'h2000_0000),
    .DepthWords(256),
    .Latency(L),
    .MaxOutstanding(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .stall_i(stall),
    .data_req_i(req),
    .data_is_cap_i(cap),
    .data_we_i(we),
    .data_be_i(be),
    .data_addr_i(addr),
    .data_wdata_i(wdata),
    .data_wdata_intg_i(wintg),
    .data_gnt_o(gnt),
    .data_rvalid_o(rvalid),
    .data_rdata_o(rdata),
    .data_rdata_intg_o(rintg),
    .data_err_o(err)
  );

  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0] c;
    m = '{32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA, 32'h3123_4ED1,
          32'hC2C1_323B, 32'h2DCC_624C, 32'h9850_5586};
    for (int j = 0; j < 7; j++) begin
      c[j] = 1'b0;
      for (int b = 0; b < 32; b++) c[j] = c[j] ^ (d[b] & m[j][b]);
    end
    return c ^ 7'b010_1010;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic c, input logic [3:0] b,
                      input logic [31:0] a, input logic [32:0] d,
                      input logic [6:0] ig,
                      output logic [32:0] rd, output logic e);
    int n;
    @(posedge clk); #1;
    req = 1'b1; we = w; cap = c; be = b; addr = a;
    wdata = d; wintg = ig;
    n = 0;
    @(negedge clk);
    while (!gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    rd = '0;
    e = 1'b0;
    if (!gnt) begin
      chk("gnt_timeout", 64'(gnt), 64'd1);
      @(posedge clk); #1 req = 1'b0;
      return;
    end
    @(posedge clk); #1 req = 1'b0;
    repeat (L - 1) @(posedge clk);
    @(negedge clk);
    chk("rvalid", 64'(rvalid), 64'd1);
    chk("rintg", 64'(rintg), 64'(enc(rdata[31:0])));
    rd = rdata;
    e = err;
  endtask

  task automatic wr(input logic c, input logic [3:0] b,
                    input logic [31:0] a, input logic [32:0] d,
                    output logic e);
    logic [32:0] rd;
    xfer(1'b1, c, b, a, d, enc(d[31:0]), rd, e);
  endtask

  task automatic rdw(input logic c, input logic [31:0] a,
                     output logic [32:0] rd, output logic e);
    xfer(1'b0, c, 4'hF, a, '0, '0, rd, e);
  endtask

  logic [32:0] r;
  logic        e;
  logic        seen;
  int          gcyc [8];
  int          rcyc [8];
  logic [32:0] rdat [8];
  int          gi, ri;
  logic        g;
  logic [31:0] tp_val [4];

  initial begin
    tp_val = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    // Reset state with a request pending.
    req = 1'b1; addr = 32'h2000_0000; be = 4'hF;
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_intg", 64'(rintg), 64'(enc(32'h0)));
    // Two outstanding reads, then reset mid-burst.
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("burst_gnt0", 64'(gnt), 64'd1);
    @(negedge clk);
    chk("burst_gnt1", 64'(gnt), 64'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    chk("midrst_gnt", 64'(gnt), 64'd0);
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | rvalid;
    end
    chk("no_stale", 64'(seen), 64'd0);
    rdw(1'b1, 32'h2000_0000, r, e);
    chk("rst_word", 64'(r), 64'd0);
    chk("rst_word_err", 64'(e), 64'd0);

    // Capability store then loads.
    wr(1'b1, 4'hF, 32'h2000_0010, 33'h1_DEAD_BEEF, e);
    chk("capst_err", 64'(e), 64'd0);
    rdw(1'b1, 32'h2000_0010, r, e);
    chk("capld", 64'(r), 64'h1_DEAD_BEEF);
    chk("capld_err", 64'(e), 64'd0);
    rdw(1'b0, 32'h2000_0010, r, e);
    chk("noncapld", 64'(r), 64'h0_DEAD_BEEF);

    // Partial write clears the tag.
    wr(1'b1, 4'b0001, 32'h2000_0010, 33'h1_0000_0055, e);
    chk("pst_err", 64'(e), 64'd0);
    rdw(1'b1, 32'h2000_0010, r, e);
    chk("tagclr", 64'(r), 64'h0_DEAD_BE55);

    // Error reads and writes.
    wr(1'b0, 4'hF, 32'h2000_0000, 33'h0_CAFE_F00D, e);
    rdw(1'b0, 32'h1FFF_FFFC, r, e);
    chk("lo_err", 64'(e), 64'd1);
    chk("lo_rdata", 64'(r), 64'd0);
    rdw(1'b0, 32'h2000_0400, r, e);
    chk("hi_err", 64'(e), 64'd1);
    chk("hi_rdata", 64'(r), 64'd0);
    rdw(1'b0, 32'h2000_0002, r, e);
    chk("mis_err", 64'(e), 64'd1);
    chk("mis_rdata", 64'(r), 64'd0);
    wr(1'b0, 4'hF, 32'h2000_0400, 33'h0_1111_1111, e);
    chk("hi_wr_err", 64'(e), 64'd1);
    wr(1'b0, 4'hF, 32'h2000_0002, 33'h0_2222_2222, e);
    chk("mis_wr_err", 64'(e), 64'd1);
    rdw(1'b0, 32'h2000_0000, r, e);
    chk("word0_kept", 64'(r), 64'h0_CAFE_F00D);
    xfer(1'b1, 1'b0, 4'hF, 32'h2000_0010, 33'h0_1234_5678,
         enc(32'h1234_5678) ^ 7'h01, r, e);
    chk("intg_err", 64'(e), 64'd1);
    chk("intg_rdata", 64'(r), 64'd0);
    rdw(1'b1, 32'h2000_0010, r, e);
    chk("intg_kept", 64'(r), 64'h0_DEAD_BE55);

    // Back-pressure and throughput.
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 4'hF, 32'h2000_0020 + 32'(4 * i), {1'b0, tp_val[i]}, e);
    end
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; cap = 1'b0; be = 4'hF; addr = 32'h2000_0020;
    gi = 0;
    ri = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      g = gnt;
      if (g && gi < 8) begin gcyc[gi] = cyc; gi++; end
      if (rvalid && ri < 8) begin
        rcyc[ri] = cyc; rdat[ri] = rdata; ri++;
      end
      @(posedge clk); #1;
      if (gi >= 4) req = 1'b0;
      else addr = 32'h2000_0020 + 32'(4 * gi);
    end
    chk("tp_ngnt", 64'(gi), 64'd4);
    chk("tp_nrsp", 64'(ri), 64'd4);
    chk("tp_g0", 64'(gcyc[0]), 64'd0);
    chk("tp_g1", 64'(gcyc[1]), 64'd1);
    chk("tp_g2", 64'(gcyc[2]), 64'd3);
    chk("tp_g3", 64'(gcyc[3]), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tp_r%0d_cyc", i), 64'(rcyc[i]), 64'(gcyc[i] + L));
      chk($sformatf("tp_r%0d_data", i), 64'(rdat[i]), 64'(tp_val[i]));
    end

    // Stall holds off the grant.
    @(posedge clk); #1;
    stall = 1'b1; req = 1'b1; we = 1'b0; cap = 1'b1; be = 4'hF;
    addr = 32'h2000_0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_gnt%0d", i), 64'(gnt), 64'd0);
      chk($sformatf("stall_rv%0d", i), 64'(rvalid), 64'd0);
    end
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    chk("unstall_gnt", 64'(gnt), 64'd1);
    @(posedge clk); #1 req = 1'b0;
    repeat (L - 1) @(posedge clk);
    @(negedge clk);
    chk("unstall_rv", 64'(rvalid), 64'd1);
    chk("unstall_rdata", 64'(rdata), 64'h0_DEAD_BE55);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
